information_demapper: RTL
=========================

# information_demapper

Inverse of the information mapper, placed on the receive side. Each cycle it pops one mapped word and its indicator vector from an input FIFO. It extracts the bits at indicator positions (lowest index first) and compacts them into a continuous bitstream. Every P accumulated bits are written to an output FIFO as one information word, so the original data words are recovered in their original order.

## Interface
- MAPPER_PARALLELISM, default 8: word width P; power of two, ≥4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mapped_fifo_empty  input  1  input FIFO empty.
- mapped_fifo_rd_data  input  P  mapped word; show-ahead, valid while not empty.
- mapping_indicators  input  P  indicator vector paired with rd_data; bit i=1 means bit i carries information.
- mapped_fifo_rd_req  output  1  pop strobe, combinational.
- data_out_fifo_full  input  1  output FIFO cannot accept a write in the next cycle (almost-full, threshold 1).
- flush  input  1  single-cycle request to emit the partial word.
- data_out_fifo_wr_req  output  1  write strobe, registered.
- data_out_fifo_wr_data  output  P  recovered word, registered.
- fill_level  output  $clog2(P)+1  bits held in the accumulator, registered.

## Operation
- k = popcount(mapping_indicators), range 0..P.
- Extraction: the j-th set indicator bit, counted from the LSB, selects rd_data at that position. That bit becomes stream bit j of this pop. Implemented as a prefix-sum and a crossbar.
- Accumulator: 2P-1 bits, LSB first. New bits are placed starting at offset fill_level.
- Pop: rd_req = !empty && !flush_pending && !(full && fill_level+k ≥ P).
- On pop with fill_level+k < P: fill_level ← fill_level+k. No write.
- On pop with fill_level+k ≥ P:
  - Emit accumulator[P-1:0] including the new bits.
  - Shift the remainder down by P.
  - fill_level ← fill_level+k−P.
- k=0 pop: the word is consumed and the state is unchanged.
- Flush:
  - A flush pulse sets flush_pending.
  - While pending, no pops occur.
  - When !full:
    - If fill_level>0, emit the accumulator low bits zero-padded to P. Then fill_level←0 and flush_pending clears.
    - If fill_level=0, flush_pending clears with no write.
- Flush arriving in the same cycle as a would-be pop: flush wins and no pop happens that cycle.
- Flush during an already pending flush: ignored.
- Reset:
  - wr_req=0, wr_data=0, fill_level=0.
  - Accumulator and flush_pending cleared.
  - Partial bits are discarded.
  - rd_req=0 while reset is asserted.
- Arithmetic: fill_level+k uses $clog2(P)+2 bits. After any update, fill_level ≤ P−1.

## Timing
- Pop at cycle t means the word is sampled at the rising edge ending t.
- When the pop completes a word, wr_req=1 and wr_data are valid in cycle t+1 for exactly one cycle.
- Throughput: one input word per cycle. At most one output word per cycle, since k ≤ P.
- full is sampled in cycle t and governs the write presented in cycle t+1. No write is ever issued in the cycle following full=1.
- Flush latency: wr_req in the cycle after flush if fill_level>0 and !full. Delayed while full is held.
- Back-to-back words with m=all-ones: wr_req held high continuously, with wr_data equal to each input word one cycle later.
- rd_req has a combinational path from empty, full, m and flush. All other outputs come directly from flops.

## Test plan
- P=8, m=8'hFF, rd_data=8'hA5 -> next cycle wr_req=1, wr_data=8'hA5, fill_level=0.
- m=8'h0F with rd_data=8'hX3, then 8'hXC -> first pop gives fill_level=4 and no write. Second pop gives wr_data=8'hC3.
- m=8'h00 for 3 pops -> rd_req=1 each cycle, no writes, fill_level unchanged.
- m=8'hAA, rd_data=8'b1000_1010, twice -> extracts 4'b1011 per pop, so wr_data=8'hBB after the second pop.
- fill_level=4, full=1, m=8'hFF -> rd_req=0 while full. Release full -> pop, wr_data correct, fill_level stays 4. A random 1000-word run with random m and full matches a reference-model output stream.
- fill_level=3 holding 3'b101, flush pulse -> wr_data=8'h05, fill_level=0. Reset asserted mid-stream -> all outputs 0 asynchronously, and the stream restarts cleanly after release.

Source files
------------

// File: rtl/information_demapper.sv
// rtl/information_demapper.sv - compacts indicator-selected bits of mapped words back into P-bit information words
module information_demapper #(
  parameter int MAPPER_PARALLELISM = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    mapped_fifo_empty,
  input  logic [MAPPER_PARALLELISM-1:0]           mapped_fifo_rd_data,
  input  logic [MAPPER_PARALLELISM-1:0]           mapping_indicators,
  output logic                                    mapped_fifo_rd_req,
  input  logic                                    data_out_fifo_full,
  input  logic                                    flush,
  output logic                                    data_out_fifo_wr_req,
  output logic [MAPPER_PARALLELISM-1:0]           data_out_fifo_wr_data,
  output logic [$clog2(MAPPER_PARALLELISM):0]     fill_level
);

  localparam int P  = MAPPER_PARALLELISM;
  localparam int FW = $clog2(P) + 1;
  localparam int SW = FW + 1;
  localparam int AW = 2 * P - 1;

  logic [AW-1:0] acc;
  logic          flush_pending;

  logic [FW-1:0] prefix [P];
  logic [FW-1:0] k;
  logic [P-1:0]  ext;
  logic [SW-1:0] sum;
  logic          word_done;
  logic [AW-1:0] merged;
  logic          flush_active;

  // prefix[i] is the stream position the bit at word index i lands on
  always_comb begin
    prefix[0] = '0;
    for (int i = 1; i < P; i++) begin
      prefix[i] = prefix[i-1] + FW'(mapping_indicators[i-1]);
    end
    k = prefix[P-1] + FW'(mapping_indicators[P-1]);
  end

  always_comb begin
    ext = '0;
    for (int j = 0; j < P; j++) begin
      for (int i = 0; i < P; i++) begin
        if (mapping_indicators[i] && (prefix[i] == FW'(j))) begin
          ext[j] = ext[j] | mapped_fifo_rd_data[i];
        end
      end
    end
  end

  // bits above fill_level in acc are always zero, so OR-merge is safe
  assign sum          = {1'b0, fill_level} + {1'b0, k};
  assign word_done    = (sum >= SW'(P));
  assign merged       = acc | (AW'(ext) << fill_level);
  assign flush_active = flush | flush_pending;

  assign mapped_fifo_rd_req = !reset && !mapped_fifo_empty && !flush_active &&
                              !(data_out_fifo_full && word_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc                   <= '0;
      flush_pending         <= 1'b0;
      fill_level            <= '0;
      data_out_fifo_wr_req  <= 1'b0;
      data_out_fifo_wr_data <= '0;
    end else begin
      data_out_fifo_wr_req <= 1'b0;
      if (mapped_fifo_rd_req) begin
        if (word_done) begin
          data_out_fifo_wr_req  <= 1'b1;
          data_out_fifo_wr_data <= merged[P-1:0];
          acc                   <= merged >> P;
          fill_level            <= FW'(sum - SW'(P));
        end else begin
          acc        <= merged;
          fill_level <= sum[FW-1:0];
        end
      end else if (flush_active) begin
        if (!data_out_fifo_full) begin
          flush_pending <= 1'b0;
          if (fill_level != '0) begin
            data_out_fifo_wr_req  <= 1'b1;
            data_out_fifo_wr_data <= acc[P-1:0];
            acc                   <= '0;
            fill_level            <= '0;
          end
        end else begin
          flush_pending <= 1'b1;
        end
      end
    end
  end

endmodule
